// File: rtl/rs_alu_pkg.sv
// Shared types and constants for the ALU reservation station.
// Covers op-type codes, the result-bus bundle, per-entry storage and operand snooping.
package rs_alu_pkg;

    localparam int unsigned ROB_TAG_W = 4;
    localparam int unsigned OP_W      = 6;
    localparam int unsigned XLEN      = 32;

    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_LB    = OP_W'(11);
    localparam logic [OP_W-1:0] OP_LH    = OP_W'(12);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(13);
    localparam logic [OP_W-1:0] OP_LBU   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_LHU   = OP_W'(15);
    localparam logic [OP_W-1:0] OP_SB    = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SH    = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(18);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(20);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(21);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(22);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(23);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(24);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(25);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(26);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(27);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(28);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(29);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(30);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(31);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(32);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(33);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(34);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(35);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(36);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(37);

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] dest;
        logic [XLEN-1:0]      value;
    } res_bus_t;

    typedef struct packed {
        logic                 pend;
        logic [ROB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      val;
    } operand_t;

    typedef struct packed {
        logic                 busy;
        logic [OP_W-1:0]      op;
        operand_t             j;
        operand_t             k;
        logic [ROB_TAG_W-1:0] dest;
    } rs_entry_t;

    // Capture a pending operand from either result bus; the ALU bus wins a tag tie.
    function automatic operand_t snoop(input operand_t opnd, input res_bus_t alu, input res_bus_t lsb);
        operand_t res;
        res = opnd;
        if (opnd.pend) begin
            if (lsb.valid && (lsb.dest == opnd.tag)) begin
                res.pend = 1'b0;
                res.val  = lsb.value;
            end
            if (alu.valid && (alu.dest == opnd.tag)) begin
                res.pend = 1'b0;
                res.val  = alu.value;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_alu_pick.sv
// Lowest-index priority encoder: one-hot, binary index and any-request flag.
module rs_pick #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]                        i_req,
    output logic [N-1:0]                        o_onehot_c,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_idx_c,
    output logic                                o_any_c
);
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    always_comb begin
        o_onehot_c = '0;
        o_idx_c    = '0;
        o_any_c    = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (i_req[i] && !o_any_c) begin
                o_onehot_c[i] = 1'b1;
                o_idx_c       = IDX_W'(i);
                o_any_c       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_alu.sv
// Integer ALU reservation station: buffers issued ops, snoops result buses,
// dispatches the lowest-index ready entry per cycle as a registered command.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int unsigned RS_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 issue_valid,
    input  logic [OP_W-1:0]      issue_op_type,
    input  logic [XLEN-1:0]      issue_vj,
    input  logic                 issue_qj_valid,
    input  logic [ROB_TAG_W-1:0] issue_qj,
    input  logic [XLEN-1:0]      issue_vk,
    input  logic                 issue_qk_valid,
    input  logic [ROB_TAG_W-1:0] issue_qk,
    input  logic [ROB_TAG_W-1:0] issue_dest,
    output logic                 rs_full,
    input  logic                 alu_res_valid,
    input  logic [ROB_TAG_W-1:0] alu_res_dest,
    input  logic [XLEN-1:0]      alu_res_value,
    input  logic                 lsb_res_valid,
    input  logic [ROB_TAG_W-1:0] lsb_res_dest,
    input  logic [XLEN-1:0]      lsb_res_value,
    input  logic                 rob_flush,
    output logic                 alu_mission,
    output logic [OP_W-1:0]      alu_op_type,
    output logic [XLEN-1:0]      alu_rs1,
    output logic [XLEN-1:0]      alu_rs2,
    output logic [ROB_TAG_W-1:0] alu_rob_dest
);
    localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    rs_entry_t          r_ent [RS_SIZE];
    rs_entry_t          w_nxt [RS_SIZE];
    rs_entry_t          w_sel_ent;
    res_bus_t           w_alu_bus;
    res_bus_t           w_lsb_bus;
    operand_t           w_iss_j;
    operand_t           w_iss_k;
    logic [RS_SIZE-1:0] w_busy;
    logic [RS_SIZE-1:0] w_free_req;
    logic [RS_SIZE-1:0] w_ready;
    logic [RS_SIZE-1:0] w_free_oh;
    logic [RS_SIZE-1:0] w_sel_oh;
    logic [IDX_W-1:0]   w_free_idx;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_free_any;
    logic               w_sel_any;

    assign w_alu_bus = '{valid: alu_res_valid, dest: alu_res_dest, value: alu_res_value};
    assign w_lsb_bus = '{valid: lsb_res_valid, dest: lsb_res_dest, value: lsb_res_value};

    // Operands arriving on a bus in the issue cycle are captured immediately.
    assign w_iss_j = snoop('{pend: issue_qj_valid, tag: issue_qj, val: issue_vj}, w_alu_bus, w_lsb_bus);
    assign w_iss_k = snoop('{pend: issue_qk_valid, tag: issue_qk, val: issue_vk}, w_alu_bus, w_lsb_bus);

    always_comb begin
        w_busy  = '0;
        w_ready = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            w_busy[i]  = r_ent[i].busy;
            w_ready[i] = r_ent[i].busy && !r_ent[i].j.pend && !r_ent[i].k.pend;
        end
    end

    assign w_free_req = ~w_busy;
    assign rs_full    = &w_busy;

    rs_pick #(.N(RS_SIZE)) u_free_pick (
        .i_req      (w_free_req),
        .o_onehot_c (w_free_oh),
        .o_idx_c    (w_free_idx),
        .o_any_c    (w_free_any)
    );

    rs_pick #(.N(RS_SIZE)) u_ready_pick (
        .i_req      (w_ready),
        .o_onehot_c (w_sel_oh),
        .o_idx_c    (w_sel_idx),
        .o_any_c    (w_sel_any)
    );

    assign w_sel_ent = r_ent[w_sel_idx];

    // Free slots come from pre-edge state, so a slot vacated by dispatch is reused next cycle.
    always_comb begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            w_nxt[i]   = r_ent[i];
            w_nxt[i].j = snoop(r_ent[i].j, w_alu_bus, w_lsb_bus);
            w_nxt[i].k = snoop(r_ent[i].k, w_alu_bus, w_lsb_bus);
            if (w_sel_any && w_sel_oh[i]) begin
                w_nxt[i].busy = 1'b0;
            end
            if (issue_valid && w_free_any && w_free_oh[i] && (w_free_idx == IDX_W'(i))) begin
                w_nxt[i] = '{busy: 1'b1, op: issue_op_type, j: w_iss_j, k: w_iss_k, dest: issue_dest};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                r_ent[i] <= '0;
            end
            alu_mission  <= 1'b0;
            alu_op_type  <= '0;
            alu_rs1      <= '0;
            alu_rs2      <= '0;
            alu_rob_dest <= '0;
        end else if (!rdy) begin
            alu_mission <= 1'b0;
        end else if (rob_flush) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                r_ent[i].busy <= 1'b0;
            end
            alu_mission <= 1'b0;
        end else begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                r_ent[i] <= w_nxt[i];
            end
            alu_mission <= w_sel_any;
            if (w_sel_any) begin
                alu_op_type  <= w_sel_ent.op;
                alu_rs1      <= w_sel_ent.j.val;
                alu_rs2      <= w_sel_ent.k.val;
                alu_rob_dest <= w_sel_ent.dest;
            end
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Directed scoreboard bench for rs_alu: expected commands are queued at stimulus
// time and popped whenever the station presents a command to the ALU.
module tb_rs_alu;
    import rs_alu_pkg::*;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [XLEN-1:0]      rs1;
        logic [XLEN-1:0]      rs2;
        logic [ROB_TAG_W-1:0] dest;
    } cmd_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rdy;
    logic                 issue_valid;
    logic [OP_W-1:0]      issue_op_type;
    logic [XLEN-1:0]      issue_vj;
    logic                 issue_qj_valid;
    logic [ROB_TAG_W-1:0] issue_qj;
    logic [XLEN-1:0]      issue_vk;
    logic                 issue_qk_valid;
    logic [ROB_TAG_W-1:0] issue_qk;
    logic [ROB_TAG_W-1:0] issue_dest;
    logic                 rs_full;
    logic                 alu_res_valid;
    logic [ROB_TAG_W-1:0] alu_res_dest;
    logic [XLEN-1:0]      alu_res_value;
    logic                 lsb_res_valid;
    logic [ROB_TAG_W-1:0] lsb_res_dest;
    logic [XLEN-1:0]      lsb_res_value;
    logic                 rob_flush;
    logic                 alu_mission;
    logic [OP_W-1:0]      alu_op_type;
    logic [XLEN-1:0]      alu_rs1;
    logic [XLEN-1:0]      alu_rs2;
    logic [ROB_TAG_W-1:0] alu_rob_dest;

    cmd_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    rs_alu #(.RS_SIZE(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .issue_valid    (issue_valid),
        .issue_op_type  (issue_op_type),
        .issue_vj       (issue_vj),
        .issue_qj_valid (issue_qj_valid),
        .issue_qj       (issue_qj),
        .issue_vk       (issue_vk),
        .issue_qk_valid (issue_qk_valid),
        .issue_qk       (issue_qk),
        .issue_dest     (issue_dest),
        .rs_full        (rs_full),
        .alu_res_valid  (alu_res_valid),
        .alu_res_dest   (alu_res_dest),
        .alu_res_value  (alu_res_value),
        .lsb_res_valid  (lsb_res_valid),
        .lsb_res_dest   (lsb_res_dest),
        .lsb_res_value  (lsb_res_value),
        .rob_flush      (rob_flush),
        .alu_mission    (alu_mission),
        .alu_op_type    (alu_op_type),
        .alu_rs1        (alu_rs1),
        .alu_rs2        (alu_rs2),
        .alu_rob_dest   (alu_rob_dest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    // Advance one edge, then score any command the station presented.
    task automatic step();
        cmd_t got;
        cmd_t want;
        @(posedge clk);
        #1;
        if (alu_mission === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_dispatch", 128'(alu_mission), 128'(0));
            end else begin
                got  = '{op: alu_op_type, rs1: alu_rs1, rs2: alu_rs2, dest: alu_rob_dest};
                want = sb.pop_front();
                chk("dispatch", 128'(got), 128'(want));
            end
        end
    endtask

    task automatic issue(input logic [OP_W-1:0] op, input logic [XLEN-1:0] vj, input logic qjv,
                         input logic [ROB_TAG_W-1:0] qj, input logic [XLEN-1:0] vk, input logic qkv,
                         input logic [ROB_TAG_W-1:0] qk, input logic [ROB_TAG_W-1:0] dest);
        issue_valid    = 1'b1;
        issue_op_type  = op;
        issue_vj       = vj;
        issue_qj_valid = qjv;
        issue_qj       = qj;
        issue_vk       = vk;
        issue_qk_valid = qkv;
        issue_qk       = qk;
        issue_dest     = dest;
    endtask

    task automatic idle_bus();
        issue_valid   = 1'b0;
        alu_res_valid = 1'b0;
        lsb_res_valid = 1'b0;
        rob_flush     = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        idle_bus();
        issue_op_type = '0; issue_vj = '0; issue_qj_valid = 1'b0; issue_qj = '0;
        issue_vk = '0; issue_qk_valid = 1'b0; issue_qk = '0; issue_dest = '0;
        alu_res_dest = '0; alu_res_value = '0; lsb_res_dest = '0; lsb_res_value = '0;

        // Reset state
        step();
        step();
        rst = 1'b1;
        chk("rst_mission", 128'(alu_mission), 128'(0));
        chk("rst_cmd", 128'({alu_op_type, alu_rs1, alu_rs2, alu_rob_dest}), 128'(0));
        chk("rst_full", 128'(rs_full), 128'(0));

        // Ready-at-issue ADD: command visible after the following edge
        issue(OP_ADD, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
        sb.push_back('{op: OP_ADD, rs1: 32'd5, rs2: 32'd7, dest: 4'd3});
        step();
        idle_bus();
        chk("add_e0_mission", 128'(alu_mission), 128'(0));
        step();
        chk("add_e1_mission", 128'(alu_mission), 128'(1));
        step();
        chk("add_e2_mission", 128'(alu_mission), 128'(0));

        // SUB waiting on tag 6, woken by the LSB bus
        issue(OP_SUB, 32'h0, 1'b1, 4'd6, 32'd1, 1'b0, 4'd0, 4'd2);
        step();
        idle_bus();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sub_wait_mission", 128'(alu_mission), 128'(0));
        end
        lsb_res_valid = 1'b1; lsb_res_dest = 4'd6; lsb_res_value = 32'h10;
        sb.push_back('{op: OP_SUB, rs1: 32'h10, rs2: 32'd1, dest: 4'd2});
        step();
        idle_bus();
        chk("sub_wake_mission", 128'(alu_mission), 128'(0));
        step();
        chk("sub_disp_mission", 128'(alu_mission), 128'(1));
        step();
        chk("sub_after_mission", 128'(alu_mission), 128'(0));

        // Issue-time snoop of operand k on the ALU bus
        issue(OP_XOR, 32'd3, 1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 4'd4);
        alu_res_valid = 1'b1; alu_res_dest = 4'd2; alu_res_value = 32'hFFFF_FFFF;
        sb.push_back('{op: OP_XOR, rs1: 32'd3, rs2: 32'hFFFF_FFFF, dest: 4'd4});
        step();
        idle_bus();
        step();
        chk("snoop_mission", 128'(alu_mission), 128'(1));
        step();

        // Fill all entries waiting on tag 9
        for (int i = 0; i < 8; i++) begin
            issue(OP_ADD, 32'h0, 1'b1, 4'd9, 32'(100 + i), 1'b0, 4'd0, 4'(i));
            step();
            idle_bus();
        end
        chk("fill_full", 128'(rs_full), 128'(1));
        issue(OP_AND, 32'hDEAD, 1'b0, 4'd0, 32'hBEEF, 1'b0, 4'd0, 4'd15);
        step();
        idle_bus();
        chk("drop_full", 128'(rs_full), 128'(1));
        chk("drop_mission", 128'(alu_mission), 128'(0));
        alu_res_valid = 1'b1; alu_res_dest = 4'd9; alu_res_value = 32'h900;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{op: OP_ADD, rs1: 32'h900, rs2: 32'(100 + i), dest: 4'(i)});
        end
        step();
        idle_bus();
        chk("wake9_full", 128'(rs_full), 128'(1));
        for (int i = 0; i < 8; i++) begin
            step();
            chk("drain_mission", 128'(alu_mission), 128'(1));
            if (i == 0) chk("drain_full_drop", 128'(rs_full), 128'(0));
        end
        step();
        chk("drain_done", 128'(alu_mission), 128'(0));
        chk("drain_sb_empty", 128'(sb.size()), 128'(0));

        // Flush with five busy entries, one of them dispatching
        for (int i = 0; i < 4; i++) begin
            issue(OP_ADD, 32'h0, 1'b1, 4'd11, 32'(i), 1'b0, 4'd0, 4'(8 + i));
            step();
        end
        issue(OP_OR, 32'h55, 1'b0, 4'd0, 32'h66, 1'b0, 4'd0, 4'd13);
        step();
        issue(OP_SLL, 32'h77, 1'b0, 4'd0, 32'h88, 1'b0, 4'd0, 4'd14);
        rob_flush = 1'b1;
        step();
        idle_bus();
        chk("flush_mission", 128'(alu_mission), 128'(0));
        chk("flush_full", 128'(rs_full), 128'(0));
        issue(OP_ADD, 32'h0, 1'b1, 4'd12, 32'hA, 1'b0, 4'd0, 4'd1);
        step();
        issue(OP_SUB, 32'hB, 1'b0, 4'd0, 32'h0, 1'b1, 4'd12, 4'd2);
        step();
        idle_bus();
        alu_res_valid = 1'b1; alu_res_dest = 4'd11; alu_res_value = 32'h1111;
        lsb_res_valid = 1'b1; lsb_res_dest = 4'd12; lsb_res_value = 32'h1212;
        sb.push_back('{op: OP_ADD, rs1: 32'h1212, rs2: 32'hA, dest: 4'd1});
        sb.push_back('{op: OP_SUB, rs1: 32'hB, rs2: 32'h1212, dest: 4'd2});
        step();
        idle_bus();
        chk("post_flush_wake", 128'(alu_mission), 128'(0));
        step();
        chk("post_flush_first", 128'(alu_mission), 128'(1));
        step();
        chk("post_flush_second", 128'(alu_mission), 128'(1));
        step();
        chk("post_flush_idle", 128'(alu_mission), 128'(0));

        // Stall with an entry ready: no dispatch and outputs hold
        issue(OP_OR, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd5);
        sb.push_back('{op: OP_OR, rs1: 32'd1, rs2: 32'd2, dest: 4'd5});
        step();
        idle_bus();
        rdy = 1'b0;
        step();
        chk("stall1_mission", 128'(alu_mission), 128'(0));
        step();
        chk("stall2_mission", 128'(alu_mission), 128'(0));
        chk("stall_hold_rs1", 128'(alu_rs1), 128'(32'hB));
        rdy = 1'b1;
        step();
        chk("resume_mission", 128'(alu_mission), 128'(1));
        step();
        chk("resume_once", 128'(alu_mission), 128'(0));
        chk("final_sb_empty", 128'(sb.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_alu.md
Name: rs_alu

Overview:
- Reservation station for the integer ALU. Sits directly upstream of the combinational ALU.
- Buffers decoded ALU/branch/JALR micro-ops from the issue stage until both operands are available.
- Snoops the two result buses (ALU and load/store buffer) to wake up waiting operands.
- Dispatches at most one ready entry per cycle to the ALU as a registered command.

Parameters:
RS_SIZE, 8, number of entries (power of two, 2..16)
ROB_TAG_W, 4, width of ROB tags
OP_W, 6, width of op-type code

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-low (state cleared at a rising edge where rst==0)
rdy  in  1  global ready; when 0, all state holds
issue_valid  in  1  new micro-op present this cycle
issue_op_type  in  OP_W  op code (shared package constants)
issue_vj  in  32  operand 1 value (valid when issue_qj_valid==0)
issue_qj_valid  in  1  operand 1 still pending
issue_qj  in  ROB_TAG_W  ROB tag producing operand 1
issue_vk  in  32  operand 2 value / immediate
issue_qk_valid  in  1  operand 2 still pending
issue_qk  in  ROB_TAG_W  ROB tag producing operand 2
issue_dest  in  ROB_TAG_W  ROB entry receiving the result
rs_full  out  1  combinational; all entries occupied
alu_res_valid  in  1  ALU result broadcast
alu_res_dest  in  ROB_TAG_W  tag of ALU result
alu_res_value  in  32  ALU result value
lsb_res_valid  in  1  load/store buffer result broadcast
lsb_res_dest  in  ROB_TAG_W  tag of LSB result
lsb_res_value  in  32  LSB result value
rob_flush  in  1  mispredict rollback; discard all contents
alu_mission  out  1  registered; command valid to ALU
alu_op_type  out  OP_W  registered op code
alu_rs1  out  32  registered operand 1
alu_rs2  out  32  registered operand 2
alu_rob_dest  out  ROB_TAG_W  registered destination tag

Behaviour:
- Reset (rst==0 at edge):
  - All entries are invalid.
  - alu_mission=0, alu_op_type=0, alu_rs1=0, alu_rs2=0, alu_rob_dest=0.
  - Reset has priority over everything else.
- Edge priority, highest first: reset, then rdy==0, then rob_flush, then normal operation.
- rdy==0: entries and all outputs except alu_mission hold; alu_mission is driven 0 so the ALU never sees a command twice.
- rob_flush: all entries are invalidated, alu_mission=0, and issue_valid is ignored that cycle. rs_full deasserts the following cycle.
- Entry fields: busy, op, vj, qj_valid, qj, vk, qk_valid, qk, dest.
- Issue:
  - When issue_valid is 1, the op is written into the lowest-index non-busy entry.
  - The issuer must not assert issue_valid while rs_full==1. If it does, the op is dropped; the bench checks that no entry is overwritten.
  - An entry freed by dispatch in a cycle is reusable only from the next cycle.
- Issue-time snoop: if issue_qj_valid==1 and a result bus valid in the same cycle carries tag issue_qj, the value is captured and qj_valid is stored as 0. Same rule for qk.
- Wakeup: every busy entry with qj_valid && qj==bus tag captures the value into vj and clears qj_valid; same for k. Both buses are snooped in parallel. On an equal-tag conflict (illegal), the ALU bus wins.
- Select:
  - Ready means busy && !qj_valid && !qk_valid, using state as it stands before the edge.
  - The lowest-index ready entry is chosen; a value woken this edge dispatches next edge at the earliest.
  - At the edge, the chosen entry is copied into the alu_* registers with alu_mission=1 and the entry is freed.
  - If no entry is ready, alu_mission=0 and the other alu_* outputs hold.
- Latency: op issued with both operands ready at edge E0 gives alu_mission=1 after E1. Wakeup at edge Ew gives dispatch after Ew+1.
- Simultaneous issue and dispatch in one cycle is supported; occupancy is unchanged.
- rs_full = AND of all busy bits (combinational from registered state).
- No arithmetic is performed here; values pass through unmodified at 32 bits.

Decomposition:
- Shared package holds:
  - op-type constants LUI=1 … AND=37 (BEQ=5, ADD=28, SUB=29, …);
  - ROB_TAG_W;
  - the result-bus bundle typedef {valid, dest, value}.
- Sub-module rs_pick: parameterised lowest-index priority encoder (RS_SIZE request bits in, one-hot/index plus any-flag out). It is instantiated twice: free-slot search and ready-entry search.

Test Plan:
- Reset then issue ADD (op 28) with vj=5, vk=7, dest=3, both ready at E0 -> alu_mission=1, alu_op_type=28, alu_rs1=5, alu_rs2=7, alu_rob_dest=3 after E1; alu_mission=0 after E2.
- Issue SUB with qj_valid=1, qj=6, vk=1. Hold 3 cycles with alu_mission==0. Then lsb_res_valid=1, dest=6, value=0x10 at Ew -> dispatch after Ew+1 with alu_rs1=0x10, alu_rs2=1.
- Issue with qk=2 pending while alu_res_valid, dest=2, value=0xFFFFFFFF in the same cycle -> the entry is ready immediately; alu_rs2=0xFFFFFFFF at the next dispatch.
- Fill 8 entries, all waiting on tag 9 -> rs_full=1. Broadcast tag 9 -> dispatches occur in index order 0..7 on consecutive cycles; rs_full drops after the first dispatch.
- With 5 entries busy and one dispatching, assert rob_flush -> alu_mission=0 next cycle, rs_full=0, and a later issue lands in entry 0.
- With an entry ready, hold rdy=0 for 2 cycles -> alu_mission=0 and no entry freed; rdy=1 -> dispatch occurs once.
